vpipe_issue_ctrl: RTL and testbench



---
 rtl/vpipe_pkg.sv | 49 ++++
 rtl/vpipe_inst_fifo.sv | 75 +++++++
 rtl/vpipe_issue_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_vpipe_issue_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vpipe_pkg.sv
// ---------------------------------------------------------------------------
// vpipe_pkg
// Shared definitions for the vpipe issue controller: instruction opcodes,
// field positions of the 8-bit instruction word, the bubble encoding, the
// issue-controller state type and small opcode decode helpers.
//
// Instruction word: [7:6] op, [5:4] rs1, [3:2] rs2, [1:0] rd
// ---------------------------------------------------------------------------
package vpipe_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 6;
  localparam int RS1_MSB = 5;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 2;
  localparam int RD_MSB  = 1;
  localparam int RD_LSB  = 0;

  localparam int NUM_REGS = 4;

  // Bubble driven onto the pipeline whenever nothing issues.
  localparam logic [7:0] NOP_INST = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } state_e;

  function automatic logic reads_rs1(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_NAND);
  endfunction

  function automatic logic reads_rs2(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_NAND);
  endfunction

  function automatic logic writes_rd(input logic [1:0] op);
    return op != OP_NOP;
  endfunction

endpackage

// File: rtl/vpipe_inst_fifo.sv
// ---------------------------------------------------------------------------
// vpipe_inst_fifo
// Synchronous instruction buffer with occupancy count. Push is ignored when
// full and pop is ignored when empty; the head entry is visible on rdata_o
// without a read latency so the controller can inspect it before popping.
//
// Ports:
//   clk      clock
//   rst      synchronous active-high reset (empties the buffer)
//   push_i   write wdata_i at the tail
//   pop_i    remove the head entry
//   wdata_i  entry to write
//   rdata_o  current head entry (undefined while empty)
//   count_o  occupancy, 0..DEPTH
//   full_o   occupancy == DEPTH
//   empty_o  occupancy == 0
// ---------------------------------------------------------------------------
module vpipe_inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; occupancy and pointers
  // define which entries are meaningful, and an unreset array maps to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vpipe_issue_ctrl.sv
// ---------------------------------------------------------------------------
// vpipe_issue_ctrl
// In-order issue controller for the 4-register, 8-bit vpipe pipeline.
// Instructions are buffered in a small FIFO; a per-register down-counter
// scoreboard tracks outstanding writes, and the head is held (NOP bubbles
// issued) while it reads a register still being written. A level drain
// request stops intake, lets the buffer empty and the scoreboard settle,
// then pulses drain_done.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_inst      incoming instruction, in_valid qualifies it
//   in_ready     buffer not full and not draining
//   drain_req    level request to quiesce
//   drain_done   one-cycle pulse when the drain has completed
//   issue_inst   registered instruction for the pipeline (NOP when idle)
//   issue_valid  registered, issue_inst is a real instruction
//   stall        registered, head was held by a hazard last cycle
//   fifo_count   buffer occupancy
// ---------------------------------------------------------------------------
module vpipe_issue_ctrl
  import vpipe_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int WB_LAT      = 3,
  parameter int BYPASS_DIST = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_inst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        drain_req,
  output logic                        drain_done,
  output logic [7:0]                  issue_inst,
  output logic                        issue_valid,
  output logic                        stall,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = ($clog2(WB_LAT + 1) < 2) ? 2 : $clog2(WB_LAT + 1);
  localparam logic [CW-1:0] CNT_WB  = CW'(WB_LAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW:0]   OCC_ONE = (AW + 1)'(1);

  state_e        state_q;
  logic [7:0]    issue_inst_q;
  logic          issue_valid_q;
  logic          stall_q;
  logic          drain_done_q;
  logic [CW-1:0] cnt_q [NUM_REGS];
  logic [CW-1:0] cnt_d [NUM_REGS];

  logic [7:0]          head;
  logic [AW:0]         occ;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [1:0]          head_op;
  logic [1:0]          head_rs1;
  logic [1:0]          head_rs2;
  logic [1:0]          head_rd;
  logic [NUM_REGS-1:0] reg_busy;
  logic                hazard;
  logic                head_blocked;
  logic                fifo_will_empty;
  logic                sb_clear_d;
  logic                drain_quiet;

  assign in_ready = !fifo_full && (state_q != DRAIN);
  assign push     = in_valid && in_ready;

  vpipe_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_inst),
    .rdata_o (head),
    .count_o (occ),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_op  = head[OP_MSB:OP_LSB];
  assign head_rs1 = head[RS1_MSB:RS1_LSB];
  assign head_rs2 = head[RS2_MSB:RS2_LSB];
  assign head_rd  = head[RD_MSB:RD_LSB];

  // A register is unsafe to read while its pending count exceeds the
  // forwarding distance; counts are the pre-update values of this cycle.
  // NOTE: every always_comb output gets a value on every path (here the loop
  // covers all entries) so no latch is inferred.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      reg_busy[r] = int'(cnt_q[r]) > BYPASS_DIST;
    end
  end

  assign hazard = (reads_rs1(head_op) && reg_busy[head_rs1]) ||
                  (reads_rs2(head_op) && reg_busy[head_rs2]);
  assign head_blocked = !fifo_empty && hazard;
  assign pop          = !fifo_empty && !hazard && (state_q != IDLE);

  assign fifo_will_empty = fifo_empty ? !push
                                      : ((occ == OCC_ONE) && pop && !push);

  // Next scoreboard: all pending counts age by one; a write issuing now
  // restarts its destination at WB_LAT, overriding the decrement.
  // NOTE: combinational blocks use blocking '=' so later statements see the
  // earlier result; clocked state is only ever updated with '<='.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_ONE : '0;
    end
    if (pop && writes_rd(head_op)) begin
      cnt_d[head_rd] = CNT_WB;
    end
  end

  always_comb begin
    sb_clear_d = 1'b1;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (cnt_d[r] != '0) sb_clear_d = 1'b0;
    end
  end

  // The drain is judged on the post-edge view so drain_done is visible in
  // the first cycle the buffer is empty and every write has landed.
  assign drain_quiet = fifo_will_empty && sb_clear_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      issue_inst_q  <= NOP_INST;
      issue_valid_q <= 1'b0;
      stall_q       <= 1'b0;
      drain_done_q  <= 1'b0;
    end else begin
      issue_inst_q  <= pop ? head : NOP_INST;
      issue_valid_q <= pop && (head_op != OP_NOP);
      stall_q       <= head_blocked;
      drain_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (drain_req)  state_q <= DRAIN;
          else if (push)  state_q <= RUN;
        end
        RUN: begin
          if (drain_req)            state_q <= DRAIN;
          else if (head_blocked)    state_q <= STALL;
          else if (fifo_will_empty) state_q <= IDLE;
        end
        STALL: begin
          // The head issues in the same cycle its hazard clears.
          if (drain_req)          state_q <= DRAIN;
          else if (!head_blocked) state_q <= fifo_will_empty ? IDLE : RUN;
        end
        DRAIN: begin
          if (drain_quiet) begin
            drain_done_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign issue_inst  = issue_inst_q;
  assign issue_valid = issue_valid_q;
  assign stall       = stall_q;
  assign drain_done  = drain_done_q;
  assign fifo_count  = occ;

endmodule

// File: tb/tb_vpipe_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vpipe_issue_ctrl
// Two controllers (no forwarding, and forwarding distance 2) receive the same
// directed stimulus. A queue-based model predicts each one's outputs every
// cycle; hand-computed literals pin the model at the key points.
// ---------------------------------------------------------------------------
module tb_vpipe_issue_ctrl;

  localparam int DEPTH  = 4;
  localparam int WB_LAT = 3;
  localparam int BYP0   = 0;
  localparam int BYP1   = 2;

  logic       clk;
  logic       rst;
  logic [7:0] in_inst;
  logic       in_valid;
  logic       drain_req;

  logic       in_ready_w    [2];
  logic       drain_done_w  [2];
  logic [7:0] issue_inst_w  [2];
  logic       issue_valid_w [2];
  logic       stall_w       [2];
  logic [2:0] fifo_count_w  [2];

  int n_checks = 0;
  int n_errors = 0;

  vpipe_issue_ctrl #(.FIFO_DEPTH(DEPTH), .WB_LAT(WB_LAT), .BYPASS_DIST(BYP0)) u_dut0 (
    .clk(clk), .rst(rst), .in_inst(in_inst), .in_valid(in_valid),
    .in_ready(in_ready_w[0]), .drain_req(drain_req), .drain_done(drain_done_w[0]),
    .issue_inst(issue_inst_w[0]), .issue_valid(issue_valid_w[0]),
    .stall(stall_w[0]), .fifo_count(fifo_count_w[0])
  );

  vpipe_issue_ctrl #(.FIFO_DEPTH(DEPTH), .WB_LAT(WB_LAT), .BYPASS_DIST(BYP1)) u_dut1 (
    .clk(clk), .rst(rst), .in_inst(in_inst), .in_valid(in_valid),
    .in_ready(in_ready_w[1]), .drain_req(drain_req), .drain_done(drain_done_w[1]),
    .issue_inst(issue_inst_w[1]), .issue_valid(issue_valid_w[1]),
    .stall(stall_w[1]), .fifo_count(fifo_count_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Each register remembers the cycle of its last issued write; a read is
  // blocked until WB_LAT+1-bypass cycles have passed since that write.
  logic [7:0] mq [2][$];
  int         lw [2][4];
  bit         draining [2];
  logic [7:0] e_inst  [2];
  bit         e_valid [2];
  bit         e_stall [2];
  bit         e_done  [2];
  int         cyc = 0;
  bit         model_ok = 1'b0;

  function automatic bit blocked(input int k, input logic [1:0] r, input int byp);
    return (cyc - lw[k][r]) < (WB_LAT + 1 - byp);
  endfunction

  task automatic model_step(input int k, input int byp);
    logic [7:0] head;
    logic [1:0] op;
    bit nonempty, hz, issue, push, quiet;
    if (rst) begin
      mq[k].delete();
      for (int r = 0; r < 4; r++) lw[k][r] = -1000;
      draining[k] = 1'b0;
      e_inst[k]  = 8'h00;
      e_valid[k] = 1'b0;
      e_stall[k] = 1'b0;
      e_done[k]  = 1'b0;
    end else begin
      push     = in_valid && (mq[k].size() < DEPTH) && !draining[k];
      nonempty = mq[k].size() != 0;
      head     = nonempty ? mq[k][0] : 8'h00;
      op       = head[7:6];
      hz       = 1'b0;
      if (nonempty && (op == 2'b01 || op == 2'b11))
        hz = blocked(k, head[5:4], byp) || blocked(k, head[3:2], byp);
      issue      = nonempty && !hz;
      e_inst[k]  = issue ? head : 8'h00;
      e_valid[k] = issue && (op != 2'b00);
      e_stall[k] = nonempty && hz;
      if (issue) begin
        if (op != 2'b00) lw[k][head[1:0]] = cyc;
        void'(mq[k].pop_front());
      end
      if (push) mq[k].push_back(in_inst);
      quiet = mq[k].size() == 0;
      for (int r = 0; r < 4; r++) if ((cyc - lw[k][r]) < WB_LAT) quiet = 1'b0;
      e_done[k] = draining[k] && quiet;
      if (e_done[k])      draining[k] = 1'b0;
      else if (drain_req) draining[k] = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, BYP0);
    model_step(1, BYP1);
    cyc++;
    model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("d%0d_issue_inst", k),  32'(issue_inst_w[k]),  32'(e_inst[k]));
        check($sformatf("d%0d_issue_valid", k), 32'(issue_valid_w[k]), 32'(e_valid[k]));
        check($sformatf("d%0d_stall", k),       32'(stall_w[k]),       32'(e_stall[k]));
        check($sformatf("d%0d_drain_done", k),  32'(drain_done_w[k]),  32'(e_done[k]));
        check($sformatf("d%0d_fifo_count", k),  32'(fifo_count_w[k]),  mq[k].size());
        check($sformatf("d%0d_in_ready", k),    32'(in_ready_w[k]),
              32'((mq[k].size() < DEPTH) && !draining[k]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = 8'h00; drain_req = 1'b0;
    tick(); tick();
    check("rst_issue_inst",  32'(issue_inst_w[0]),  32'h00);
    check("rst_issue_valid", 32'(issue_valid_w[0]), 0);
    check("rst_stall",       32'(stall_w[0]),       0);
    check("rst_drain_done",  32'(drain_done_w[0]),  0);
    check("rst_fifo_count",  32'(fifo_count_w[0]),  0);
    check("rst_in_ready",    32'(in_ready_w[0]),    1);
    rst = 1'b0;
    tick();

    // Single SET r1: one cycle from accept to issue, then back to bubble.
    in_inst = 8'h81; in_valid = 1'b1; tick(); in_valid = 1'b0;
    check("t1_count_after_push", 32'(fifo_count_w[0]),  1);
    check("t1_not_yet_issued",   32'(issue_valid_w[0]), 0);
    tick();
    check("t1_issue_inst",  32'(issue_inst_w[0]),  32'h81);
    check("t1_issue_valid", 32'(issue_valid_w[0]), 1);
    tick();
    check("t1_back_to_nop", 32'(issue_inst_w[0]),  32'h00);
    idle(6);

    // SET r1 then ADD r2=r1+r0: 3 stalls without forwarding, 1 with BYPASS 2.
    in_inst = 8'h81; in_valid = 1'b1; tick();
    in_inst = 8'h52; tick();
    in_valid = 1'b0;
    tick();
    check("raw_d0_stall_1", 32'(stall_w[0]), 1);
    check("raw_d1_stall_1", 32'(stall_w[1]), 1);
    tick();
    check("raw_d0_stall_2",    32'(stall_w[0]),      1);
    check("raw_d1_add_issued", 32'(issue_inst_w[1]), 32'h52);
    check("raw_d1_no_stall",   32'(stall_w[1]),      0);
    tick();
    check("raw_d0_stall_3", 32'(stall_w[0]),      1);
    check("raw_d1_nop",     32'(issue_inst_w[1]), 32'h00);
    tick();
    check("raw_d0_add_issued", 32'(issue_inst_w[0]),  32'h52);
    check("raw_d0_add_valid",  32'(issue_valid_w[0]), 1);
    check("raw_d0_stall_done", 32'(stall_w[0]),       0);
    idle(6);

    // Fill the buffer behind a blocked ADD, then offer a fifth entry.
    in_valid = 1'b1;
    in_inst = 8'h81; tick();
    in_inst = 8'h52; tick();
    in_inst = 8'h83; tick();
    in_inst = 8'h80; tick();
    in_inst = 8'h82; tick();
    check("full_count",    32'(fifo_count_w[0]), 4);
    check("full_in_ready", 32'(in_ready_w[0]),   0);
    check("full_stall",    32'(stall_w[0]),      1);
    in_inst = 8'h84; tick();
    in_valid = 1'b0;
    check("full_fifth_rejected", 32'(fifo_count_w[0]), 3);
    check("full_ready_again",    32'(in_ready_w[0]),   1);
    check("full_head_issued",    32'(issue_inst_w[0]), 32'h52);
    idle(10);

    // Drain with two entries left; d1 sees drain_req held across IDLE.
    in_valid = 1'b1;
    in_inst = 8'h81; tick();
    in_inst = 8'h52; tick();
    in_inst = 8'h83; tick();
    in_valid = 1'b0; drain_req = 1'b1;
    tick();
    check("drain_d0_not_ready", 32'(in_ready_w[0]), 0);
    check("drain_d1_not_ready", 32'(in_ready_w[1]), 0);
    tick();
    tick();
    check("drain_d0_issue_add", 32'(issue_inst_w[0]), 32'h52);
    tick();
    check("drain_d0_issue_set", 32'(issue_inst_w[0]), 32'h83);
    tick();
    check("drain_d0_not_done_1", 32'(drain_done_w[0]), 0);
    check("drain_d1_done_1",     32'(drain_done_w[1]), 1);
    tick();
    check("drain_d0_not_done_2", 32'(drain_done_w[0]), 0);
    check("drain_d1_gap",        32'(drain_done_w[1]), 0);
    tick();
    check("drain_d0_done",   32'(drain_done_w[0]), 1);
    check("drain_d1_done_2", 32'(drain_done_w[1]), 1);
    drain_req = 1'b0;
    tick();
    check("drain_d0_pulse_end", 32'(drain_done_w[0]), 0);
    check("drain_d0_idle_ready", 32'(in_ready_w[0]),  1);
    check("drain_d1_idle_ready", 32'(in_ready_w[1]),  1);
    idle(4);

    // Reset while stalled with three entries queued.
    in_valid = 1'b1;
    in_inst = 8'h81; tick();
    in_inst = 8'h52; tick();
    in_inst = 8'h83; tick();
    in_inst = 8'h80; tick();
    in_valid = 1'b0;
    check("rst_mid_pre_count", 32'(fifo_count_w[0]), 3);
    check("rst_mid_pre_stall", 32'(stall_w[0]),      1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_count", 32'(fifo_count_w[0]),  0);
    check("rst_mid_valid", 32'(issue_valid_w[0]), 0);
    check("rst_mid_stall", 32'(stall_w[0]),       0);
    // Scoreboard cleared: an ADD reading r1 issues without a bubble.
    in_inst = 8'h52; in_valid = 1'b1; tick(); in_valid = 1'b0;
    tick();
    check("rst_mid_add_issued", 32'(issue_inst_w[0]), 32'h52);
    check("rst_mid_add_nostall", 32'(stall_w[0]),     0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
